// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and issue-stage state encoding.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_QUO   = 5'b00011;
    localparam logic [4:0] OP_REM   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_XOR   = 5'b00111;
    localparam logic [4:0] OP_PASSA = 5'b10110;
    localparam logic [4:0] OP_PASSB = 5'b10111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EXEC     = 2'b01,
        DIV_WAIT = 2'b10
    } issue_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_QUO) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
// Register 0 is never written and always reads as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs_r [NREGS];

    // Storage: cleared on reset, written on commit except for r0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs_r[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs_r[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage in front of the combinational ALU, with result
// forwarding and a counted hold of the ALU inputs for quotient/remainder ops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int NREGS      = 8,
    parameter  int DIV_CYCLES = 4,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       flags_q,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int             CW      = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_DIV = CW'(DIV_CYCLES);

    issue_state_e     state_r, state_n_s;
    logic [CW-1:0]    cnt_r, cnt_n_s;
    logic [AW-1:0]    e_rd_r;
    logic [WIDTH-1:0] alu_a_r, alu_b_r;
    logic [4:0]       alu_opcode_r;
    logic             wb_valid_r;
    logic [AW-1:0]    wb_rd_r;
    logic [WIDTH-1:0] wb_data_r;
    logic [2:0]       flags_r;

    logic             commit_s, ready_s, accept_s;
    logic             fwd_a_s, fwd_b_s;
    logic [WIDTH-1:0] rf_a_s, rf_b_s, op_a_s, op_b_s;

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (commit_s),
        .waddr    (e_rd_r),
        .wdata    (alu_result),
        .raddr_a  (in_rs1),
        .rdata_a  (rf_a_s),
        .raddr_b  (in_rs2),
        .rdata_b  (rf_b_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Commit and readiness depend only on registered state, never on in_valid.
    always_comb begin
        commit_s = 1'b0;
        ready_s  = 1'b1;
        case (state_r)
            IDLE: begin
                commit_s = 1'b0;
                ready_s  = 1'b1;
            end
            EXEC: begin
                commit_s = 1'b1;
                ready_s  = 1'b1;
            end
            DIV_WAIT: begin
                commit_s = (cnt_r == CNT_ONE);
                ready_s  = (cnt_r == CNT_ONE);
            end
            default: begin
                commit_s = 1'b0;
                ready_s  = 1'b1;
            end
        endcase
    end

    assign accept_s = in_valid && ready_s;
    assign in_ready = ready_s;

    // An operand takes the result being committed this cycle instead of the stale register.
    assign fwd_a_s = commit_s && (e_rd_r != '0) && (in_rs1 == e_rd_r);
    assign fwd_b_s = commit_s && (e_rd_r != '0) && (in_rs2 == e_rd_r);
    assign op_a_s  = fwd_a_s ? alu_result : rf_a_s;
    assign op_b_s  = in_use_imm ? in_imm : (fwd_b_s ? alu_result : rf_b_s);

    // Next-state and hold-counter logic.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        if (accept_s) begin
            if (is_div_op(in_opcode)) begin
                state_n_s = DIV_WAIT;
                cnt_n_s   = CNT_DIV;
            end else begin
                state_n_s = EXEC;
                cnt_n_s   = '0;
            end
        end else if (commit_s) begin
            state_n_s = IDLE;
            cnt_n_s   = '0;
        end else if (state_r == DIV_WAIT) begin
            cnt_n_s   = cnt_r - CNT_ONE;
        end else begin
            state_n_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Operand issue and writeback registers; ALU inputs hold their values while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_opcode_r <= 5'b00000;
            e_rd_r       <= '0;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= '0;
            wb_data_r    <= '0;
            flags_r      <= 3'b000;
        end else begin
            if (accept_s) begin
                alu_a_r      <= op_a_s;
                alu_b_r      <= op_b_s;
                alu_opcode_r <= in_opcode;
                e_rd_r       <= in_rd;
            end
            wb_valid_r <= commit_s;
            if (commit_s) begin
                wb_rd_r         <= e_rd_r;
                wb_data_r       <= alu_result;
                flags_r[FLAG_Z] <= alu_zero;
                flags_r[FLAG_C] <= alu_carry;
                flags_r[FLAG_V] <= alu_overflow;
            end
        end
    end

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;
    assign wb_valid   = wb_valid_r;
    assign wb_rd      = wb_rd_r;
    assign wb_data    = wb_data_r;
    assign flags_q    = flags_r;

endmodule
